// File: rtl/hash_table_requester.sv
// Initiator front end for the chained hash table: one command in flight, op held on the
// table port until DONE or watchdog expiry, result returned on a valid/ready response stream.
module hash_table_requester #(
  parameter int KEY_WIDTH      = 32,
  parameter int VALUE_WIDTH    = 64,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [KEY_WIDTH-1:0]   cmd_key,
  input  logic [VALUE_WIDTH-1:0] cmd_value,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [1:0]             rsp_op,
  output logic [KEY_WIDTH-1:0]   rsp_key,
  output logic [VALUE_WIDTH-1:0] rsp_value,
  output logic                   rsp_success,
  output logic                   rsp_timeout,
  output logic [1:0]             ht_op,
  output logic [KEY_WIDTH-1:0]   ht_key,
  output logic [VALUE_WIDTH-1:0] ht_value,
  input  logic [VALUE_WIDTH-1:0] ht_value_out,
  input  logic                   ht_success,
  input  logic [1:0]             ht_state,
  output logic [CNT_WIDTH-1:0]   stat_ops,
  output logic [CNT_WIDTH-1:0]   stat_success,
  output logic [CNT_WIDTH-1:0]   stat_timeouts
);
  localparam logic [1:0] OP_NOOP = 2'd0;
  localparam logic [1:0] HT_IDLE = 2'd0;
  localparam logic [1:0] HT_DONE = 2'd3;
  localparam int         WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} state_e;

  state_e                 state_q, state_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [1:0]             rsp_op_q, rsp_op_d;
  logic [KEY_WIDTH-1:0]   rsp_key_q, rsp_key_d;
  logic [VALUE_WIDTH-1:0] rsp_value_q, rsp_value_d;
  logic                   rsp_success_q, rsp_success_d;
  logic                   rsp_timeout_q, rsp_timeout_d;
  logic [1:0]             ht_op_q, ht_op_d;
  logic [KEY_WIDTH-1:0]   ht_key_q, ht_key_d;
  logic [VALUE_WIDTH-1:0] ht_value_q, ht_value_d;
  logic [WD_W-1:0]        wdog_q, wdog_d;
  logic [CNT_WIDTH-1:0]   stat_ops_q, stat_ops_d;
  logic [CNT_WIDTH-1:0]   stat_success_q, stat_success_d;
  logic [CNT_WIDTH-1:0]   stat_timeouts_q, stat_timeouts_d;
  logic                   wd_expire;
  logic                   ht_done;

  // wdog_q holds cycles already spent; this cycle is the (wdog_q+1)-th
  assign wd_expire = (wdog_q + 1'b1) == WD_LIMIT;
  assign ht_done   = (state_q == R_WAIT) && (ht_state == HT_DONE);

  always_comb begin
    state_d         = state_q;
    cmd_ready_d     = cmd_ready_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_op_d        = rsp_op_q;
    rsp_key_d       = rsp_key_q;
    rsp_value_d     = rsp_value_q;
    rsp_success_d   = rsp_success_q;
    rsp_timeout_d   = rsp_timeout_q;
    ht_op_d         = ht_op_q;
    ht_key_d        = ht_key_q;
    ht_value_d      = ht_value_q;
    wdog_d          = wdog_q;
    stat_ops_d      = stat_ops_q;
    stat_success_d  = stat_success_q;
    stat_timeouts_d = stat_timeouts_q;
    unique case (state_q)
      R_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          ht_op_d     = cmd_op;
          ht_key_d    = cmd_key;
          ht_value_d  = cmd_value;
          rsp_op_d    = cmd_op;
          rsp_key_d   = cmd_key;
          wdog_d      = '0;
          cmd_ready_d = 1'b0;
          if (cmd_op == OP_NOOP) begin
            // NOOP never reaches the table and is not counted
            rsp_value_d   = '0;
            rsp_success_d = 1'b0;
            rsp_timeout_d = 1'b0;
            rsp_valid_d   = 1'b1;
            state_d       = R_RESP;
          end else begin
            state_d = R_ISSUE;
          end
        end
      end
      R_ISSUE, R_WAIT: begin
        wdog_d = wdog_q + 1'b1;
        if (ht_done) begin
          rsp_value_d    = ht_value_out;
          rsp_success_d  = ht_success;
          rsp_timeout_d  = 1'b0;
          rsp_valid_d    = 1'b1;
          ht_op_d        = OP_NOOP;
          stat_ops_d     = stat_ops_q + 1'b1;
          stat_success_d = stat_success_q + CNT_WIDTH'(ht_success);
          state_d        = R_RESP;
        end else if (wd_expire) begin
          rsp_value_d     = '0;
          rsp_success_d   = 1'b0;
          rsp_timeout_d   = 1'b1;
          rsp_valid_d     = 1'b1;
          ht_op_d         = OP_NOOP;
          stat_ops_d      = stat_ops_q + 1'b1;
          stat_timeouts_d = stat_timeouts_q + 1'b1;
          state_d         = R_RESP;
        end else if (state_q == R_ISSUE && ht_state == HT_IDLE) begin
          // table samples the held op on this edge; a DONE seen before this is stale
          state_d = R_WAIT;
        end
      end
      R_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d   = 1'b0;
          rsp_timeout_d = 1'b0;
          cmd_ready_d   = 1'b1;
          state_d       = R_IDLE;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= R_IDLE;
      cmd_ready_q     <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_op_q        <= OP_NOOP;
      rsp_key_q       <= '0;
      rsp_value_q     <= '0;
      rsp_success_q   <= 1'b0;
      rsp_timeout_q   <= 1'b0;
      ht_op_q         <= OP_NOOP;
      ht_key_q        <= '0;
      ht_value_q      <= '0;
      wdog_q          <= '0;
      stat_ops_q      <= '0;
      stat_success_q  <= '0;
      stat_timeouts_q <= '0;
    end else begin
      state_q         <= state_d;
      cmd_ready_q     <= cmd_ready_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_op_q        <= rsp_op_d;
      rsp_key_q       <= rsp_key_d;
      rsp_value_q     <= rsp_value_d;
      rsp_success_q   <= rsp_success_d;
      rsp_timeout_q   <= rsp_timeout_d;
      ht_op_q         <= ht_op_d;
      ht_key_q        <= ht_key_d;
      ht_value_q      <= ht_value_d;
      wdog_q          <= wdog_d;
      stat_ops_q      <= stat_ops_d;
      stat_success_q  <= stat_success_d;
      stat_timeouts_q <= stat_timeouts_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_op        = rsp_op_q;
  assign rsp_key       = rsp_key_q;
  assign rsp_value     = rsp_value_q;
  assign rsp_success   = rsp_success_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign ht_op         = ht_op_q;
  assign ht_key        = ht_key_q;
  assign ht_value      = ht_value_q;
  assign stat_ops      = stat_ops_q;
  assign stat_success  = stat_success_q;
  assign stat_timeouts = stat_timeouts_q;
endmodule

// File: tb/tb_hash_table_requester.sv
// Bench for hash_table_requester: behavioural chained-table model on the ht_* side,
// directed scenarios then random commands checked against a key/value reference map.
module tb_hash_table_requester;
  localparam int KW = 32, VW = 64, TO = 16, CW = 32, POOL = 24;

  logic          clk = 1'b0, rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [KW-1:0] cmd_key = '0;
  logic [VW-1:0] cmd_value = '0;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [1:0]    rsp_op;
  logic [KW-1:0] rsp_key;
  logic [VW-1:0] rsp_value;
  logic          rsp_success, rsp_timeout;
  logic [1:0]    ht_op, ht_state;
  logic [KW-1:0] ht_key;
  logic [VW-1:0] ht_value, ht_value_out;
  logic          ht_success;
  logic [CW-1:0] stat_ops, stat_success, stat_timeouts;
  int            n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  hash_table_requester #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_key(cmd_key), .cmd_value(cmd_value),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_key(rsp_key),
    .rsp_value(rsp_value), .rsp_success(rsp_success), .rsp_timeout(rsp_timeout),
    .ht_op(ht_op), .ht_key(ht_key), .ht_value(ht_value),
    .ht_value_out(ht_value_out), .ht_success(ht_success), .ht_state(ht_state),
    .stat_ops(stat_ops), .stat_success(stat_success), .stat_timeouts(stat_timeouts));

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Table model: 8192 buckets, new keys prepended to their chain, one SEARCHING cycle per hop.
  logic          stuck = 1'b0;
  logic [1:0]    t_state = '0, t_op = '0;
  logic [KW-1:0] t_key = '0;
  logic [VW-1:0] t_val = '0;
  logic          t_succ = 1'b0, t_ins = 1'b0;
  int            t_hops = 0;
  logic [KW-1:0] t_keys[$];
  logic [VW-1:0] t_kv[logic [KW-1:0]];

  assign ht_state     = stuck ? 2'd1 : t_state;
  assign ht_value_out = t_val;
  assign ht_success   = t_succ;

  always @(posedge clk) begin : tbl
    int pos, len, idx;
    if (rst) t_state <= 2'd0;
    else if (!stuck) begin
      case (t_state)
        2'd0: if (ht_op != 2'd0) begin
          pos = -1; len = 0; idx = -1;
          for (int i = t_keys.size() - 1; i >= 0; i--)
            if (t_keys[i][12:0] == ht_key[12:0]) begin
              if (t_keys[i] == ht_key) begin pos = len; idx = i; end
              len++;
            end
          t_op <= ht_op; t_key <= ht_key; t_ins <= 1'b0; t_state <= 2'd1;
          t_hops <= (pos >= 0) ? pos + 1 : ((len > 0) ? len : 1);
          if (pos >= 0) begin
            t_val <= t_kv[ht_key]; t_succ <= 1'b1;
            if (ht_op == 2'd1) t_kv[ht_key] = ht_value;
            else if (ht_op == 2'd3) begin t_kv.delete(ht_key); t_keys.delete(idx); end
          end else if (ht_op == 2'd1 && t_keys.size() < POOL) begin
            t_val <= ht_value; t_succ <= 1'b1; t_ins <= 1'b1;
            t_kv[ht_key] = ht_value; t_keys.push_back(ht_key);
          end else begin
            t_val <= '0; t_succ <= 1'b0;
          end
        end
        2'd1: if (t_hops > 1) t_hops <= t_hops - 1; else t_state <= t_ins ? 2'd2 : 2'd3;
        2'd2: t_state <= 2'd3;
        default: t_state <= 2'd0;
      endcase
    end
  end

  // The table port must hold still for as long as the table is walking the chain.
  always @(negedge clk)
    if (!rst && !stuck && t_state == 2'd1) begin
      chk("ht_op_hold", 64'(ht_op), 64'(t_op));
      chk("ht_key_hold", 64'(ht_key), 64'(t_key));
    end

  // Reference: plain key -> value map with pool capacity.
  logic [VW-1:0] ref_kv[logic [KW-1:0]];
  int exp_ops = 0, exp_succ = 0, exp_to = 0;

  task automatic chk_stats(input string tag);
    chk({tag, "_stat_ops"}, 64'(stat_ops), 64'(exp_ops));
    chk({tag, "_stat_success"}, 64'(stat_success), 64'(exp_succ));
    chk({tag, "_stat_timeouts"}, 64'(stat_timeouts), 64'(exp_to));
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [KW-1:0] k, input logic [VW-1:0] v,
                         input int hold, input bit want_to, input int want_lat);
    logic [VW-1:0] e_val;
    logic          e_succ;
    int            lat, w;
    e_val = '0; e_succ = 1'b0;
    if (!want_to && op == 2'd1) begin
      if (ref_kv.exists(k)) begin e_val = ref_kv[k]; e_succ = 1'b1; ref_kv[k] = v; end
      else if (ref_kv.num() < POOL) begin e_val = v; e_succ = 1'b1; ref_kv[k] = v; end
    end else if (!want_to && op != 2'd0 && ref_kv.exists(k)) begin
      e_val = ref_kv[k]; e_succ = 1'b1;
      if (op == 2'd3) ref_kv.delete(k);
    end
    w = 0;
    while (cmd_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    if (cmd_ready !== 1'b1) begin chk("cmd_ready_wait", 64'(cmd_ready), 64'd1); return; end
    cmd_valid = 1'b1; cmd_op = op; cmd_key = k; cmd_value = v;
    @(negedge clk);
    cmd_valid = 1'b0; lat = 1;
    while (rsp_valid !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
    chk("rsp_valid_wait", 64'(rsp_valid), 64'd1);
    if (rsp_valid !== 1'b1) return;
    if (want_lat > 0) chk("latency", 64'(lat), 64'(want_lat));
    chk("rsp_op", 64'(rsp_op), 64'(op));
    chk("rsp_key", 64'(rsp_key), 64'(k));
    chk("rsp_value", rsp_value, e_val);
    chk("rsp_success", 64'(rsp_success), 64'(e_succ));
    chk("rsp_timeout", 64'(rsp_timeout), 64'(want_to));
    chk("cmd_ready_in_resp", 64'(cmd_ready), 64'd0);
    if (op != 2'd0) begin exp_ops++; exp_succ += int'(e_succ); exp_to += int'(want_to); end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_value", rsp_value, e_val);
      chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 64'(rsp_valid), 64'd0);
    chk("cmd_ready_b2b", 64'(cmd_ready), 64'd1);
    chk_stats("post");
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_ht_op", 64'(ht_op), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk_stats("rst");
    rst = 1'b0;
    @(negedge clk);
    chk("cmd_ready_rise", 64'(cmd_ready), 64'd1);

    // insert / lookup / overwrite / erase on one key
    run_cmd(2'd1, 32'h15, 64'hAAAA, 0, 1'b0, 5);
    run_cmd(2'd2, 32'h15, 64'h0,    0, 1'b0, 4);
    run_cmd(2'd1, 32'h15, 64'hBBBB, 0, 1'b0, 4);
    run_cmd(2'd2, 32'h15, 64'h0,    0, 1'b0, 4);
    run_cmd(2'd3, 32'h15, 64'h0,    0, 1'b0, 4);
    run_cmd(2'd2, 32'h15, 64'h0,    0, 1'b0, 4);

    // same bucket: first-inserted key sits one hop down the chain
    run_cmd(2'd1, 32'h0003, 64'h1111, 0, 1'b0, 5);
    run_cmd(2'd1, 32'h2003, 64'h2222, 0, 1'b0, 5);
    run_cmd(2'd2, 32'h0003, 64'h0,    0, 1'b0, 5);
    run_cmd(2'd2, 32'h2003, 64'h0,    0, 1'b0, 4);

    // watchdog with the table stuck busy, then recovery
    stuck = 1'b1;
    run_cmd(2'd2, 32'h2003, 64'h0, 0, 1'b1, TO + 1);
    chk("to_ht_op_noop", 64'(ht_op), 64'd0);
    stuck = 1'b0;
    run_cmd(2'd2, 32'h2003, 64'h0, 0, 1'b0, 4);

    // backpressure and NOOP
    run_cmd(2'd2, 32'h0003, 64'h0, 5, 1'b0, 5);
    run_cmd(2'd0, 32'h77, 64'h1234, 0, 1'b0, 1);

    // reset while waiting on the table
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_key = 32'h0003; cmd_value = '0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ht_op", 64'(ht_op), 64'd0);
    chk("mid_rst_ht_key", 64'(ht_key), 64'd0);
    chk("mid_rst_ht_value", ht_value, 64'd0);
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_rsp_key", 64'(rsp_key), 64'd0);
    exp_ops = 0; exp_succ = 0; exp_to = 0;
    chk_stats("mid_rst");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_rsp_after_rst", 64'(rsp_valid), 64'd0);
    end
    run_cmd(2'd2, 32'h0003, 64'h0, 0, 1'b0, 5);

    // random traffic over 4 buckets x 10 keys, pool fills and drains
    for (int n = 0; n < 150; n++) begin
      logic [1:0]    op;
      logic [KW-1:0] k;
      logic [VW-1:0] v;
      op = 2'($urandom_range(0, 3));
      k  = KW'(($urandom_range(0, 9) << 13) | $urandom_range(0, 3));
      v  = {$urandom, $urandom};
      run_cmd(op, k, v, int'($urandom_range(0, 2)), 1'b0, 0);
    end
    chk_stats("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
